if_weight_mem_arbiter: RTL and testbench

Owns the single weight-memory port of an IF neuron layer (mem_addr/mem_din/mem_wen/mem_dout, address = {neuron index, weight index}). Shares it between a host single-word read/write requester and a bulk weight loader. The loader streams a full NUM_NEURONS x NUM_INPUTS weight image into the layer. All writes are held off while inference is active.

---
 rtl/snn_mem_pkg.sv | 20 ++
 rtl/if_weight_mem_arbiter_if.sv | 37 +++
 rtl/weight_addr_counter.sv | 54 +++++
 rtl/if_weight_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_if_weight_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_mem_pkg.sv
// Shared types and helpers for the IF-layer weight-memory controllers.
package snn_mem_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHostWr,
    StHostRd,
    StLoad,
    StLoadDone
  } arb_state_e;

  // Build a flat weight-memory address from its neuron and weight fields.
  // Computed at 64 bits; callers truncate to their address width.
  function automatic logic [63:0] compose_addr(input logic [63:0] neuron_idx,
                                               input logic [63:0] weight_idx,
                                               input int unsigned weight_addr_width);
    return (neuron_idx << weight_addr_width) | weight_idx;
  endfunction

endpackage

// File: rtl/if_weight_mem_arbiter_if.sv
// Host, bulk-loader and weight-memory signals of the arbiter.
interface if_weight_mem_arbiter_if #(
  parameter int unsigned WEIGHT_SIZE       = 32,
  parameter int unsigned NEURON_ADDR_WIDTH = 28
);
  logic                         host_req;
  logic                         host_we;
  logic [NEURON_ADDR_WIDTH-1:0] host_addr;
  logic [WEIGHT_SIZE-1:0]       host_wdata;
  logic                         host_ack;
  logic [WEIGHT_SIZE-1:0]       host_rdata;
  logic                         load_start;
  logic                         load_valid;
  logic [WEIGHT_SIZE-1:0]       load_data;
  logic                         load_ready;
  logic                         load_busy;
  logic                         load_done;
  logic [NEURON_ADDR_WIDTH-1:0] mem_addr;
  logic [WEIGHT_SIZE-1:0]       mem_din;
  logic                         mem_wen;
  logic [WEIGHT_SIZE-1:0]       mem_dout;

  // Arbiter side: serves the requesters and owns the memory port.
  modport slave (
    input  host_req, host_we, host_addr, host_wdata, load_start, load_valid, load_data,
           mem_dout,
    output host_ack, host_rdata, load_ready, load_busy, load_done, mem_addr, mem_din, mem_wen
  );

  // Requester / layer side.
  modport master (
    output host_req, host_we, host_addr, host_wdata, load_start, load_valid, load_data,
           mem_dout,
    input  host_ack, host_rdata, load_ready, load_busy, load_done, mem_addr, mem_din, mem_wen
  );

endinterface

// File: rtl/weight_addr_counter.sv
// Nested weight/neuron index counter walking a full weight image.
module weight_addr_counter #(
  parameter int unsigned NUM_INPUTS       = 4,
  parameter int unsigned NUM_NEURONS      = 1,
  parameter int unsigned WEIGHT_IDX_WIDTH = 10,
  parameter int unsigned NEURON_IDX_WIDTH = 18
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clr_i,
  input  logic                        inc_i,
  output logic [WEIGHT_IDX_WIDTH-1:0] weight_idx_o,
  output logic [NEURON_IDX_WIDTH-1:0] neuron_idx_o,
  output logic                        last_o
);

  logic [WEIGHT_IDX_WIDTH-1:0] weight_idx_q, weight_idx_d;
  logic [NEURON_IDX_WIDTH-1:0] neuron_idx_q, neuron_idx_d;
  logic                        weight_wrap;

  assign weight_wrap  = (weight_idx_q == WEIGHT_IDX_WIDTH'(NUM_INPUTS - 1));
  assign last_o       = weight_wrap && (neuron_idx_q == NEURON_IDX_WIDTH'(NUM_NEURONS - 1));
  assign weight_idx_o = weight_idx_q;
  assign neuron_idx_o = neuron_idx_q;

  // Next index: clear wins over increment; weight wraps into the neuron count.
  always_comb begin
    weight_idx_d = weight_idx_q;
    neuron_idx_d = neuron_idx_q;
    if (clr_i) begin
      weight_idx_d = '0;
      neuron_idx_d = '0;
    end else if (inc_i) begin
      if (weight_wrap) begin
        weight_idx_d = '0;
        neuron_idx_d = neuron_idx_q + NEURON_IDX_WIDTH'(1);
      end else begin
        weight_idx_d = weight_idx_q + WEIGHT_IDX_WIDTH'(1);
      end
    end
  end

  // Index registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      weight_idx_q <= '0;
      neuron_idx_q <= '0;
    end else begin
      weight_idx_q <= weight_idx_d;
      neuron_idx_q <= neuron_idx_d;
    end
  end

endmodule

// File: rtl/if_weight_mem_arbiter.sv
// Shares the IF layer's single weight-memory port between host word
// accesses and a bulk weight loader; writes are held off during inference.
module if_weight_mem_arbiter
  import snn_mem_pkg::*;
#(
  parameter int unsigned WEIGHT_SIZE       = 32,
  parameter int unsigned NUM_INPUTS        = 4,
  parameter int unsigned NUM_NEURONS       = 1,
  parameter int unsigned NEURON_ADDR_WIDTH = 28,
  parameter int unsigned WEIGHT_ADDR_WIDTH = 10,
  parameter int unsigned RD_LATENCY        = 1
) (
  input logic                    clk,
  input logic                    rst,
  input logic                    infer_active,
  if_weight_mem_arbiter_if.slave bus
);

  localparam int unsigned NeuronIdxWidth = NEURON_ADDR_WIDTH - WEIGHT_ADDR_WIDTH;
  localparam int unsigned RdCntWidth     = $clog2(RD_LATENCY + 1);

  if (NUM_INPUTS > (64'd1 << WEIGHT_ADDR_WIDTH)) begin : g_chk_inputs
    $error("NUM_INPUTS does not fit in WEIGHT_ADDR_WIDTH");
  end
  if (NUM_NEURONS > (64'd1 << NeuronIdxWidth)) begin : g_chk_neurons
    $error("NUM_NEURONS does not fit in the neuron address field");
  end
  if (RD_LATENCY < 1) begin : g_chk_latency
    $error("RD_LATENCY must be at least 1");
  end

  arb_state_e                  state_q, state_d;
  logic                        pending_load_q, pending_load_d;
  logic [RdCntWidth-1:0]       rd_cnt_q, rd_cnt_d;
  logic [WEIGHT_SIZE-1:0]      rdata_q, rdata_d;
  logic                        cnt_clr, cnt_inc, cnt_last;
  logic [WEIGHT_ADDR_WIDTH-1:0] weight_idx;
  logic [NeuronIdxWidth-1:0]   neuron_idx;

  weight_addr_counter #(
    .NUM_INPUTS      (NUM_INPUTS),
    .NUM_NEURONS     (NUM_NEURONS),
    .WEIGHT_IDX_WIDTH(WEIGHT_ADDR_WIDTH),
    .NEURON_IDX_WIDTH(NeuronIdxWidth)
  ) u_cnt (
    .clk_i       (clk),
    .rst_ni      (rst),
    .clr_i       (cnt_clr),
    .inc_i       (cnt_inc),
    .weight_idx_o(weight_idx),
    .neuron_idx_o(neuron_idx),
    .last_o      (cnt_last)
  );

  // Arbitration FSM: next state and all port outputs.
  always_comb begin
    state_d        = state_q;
    pending_load_d = pending_load_q;
    rd_cnt_d       = '0;
    rdata_d        = rdata_q;
    cnt_clr        = 1'b0;
    cnt_inc        = 1'b0;
    bus.host_ack   = 1'b0;
    bus.host_rdata = rdata_q;
    bus.mem_addr   = '0;
    bus.mem_din    = '0;
    bus.mem_wen    = 1'b0;
    bus.load_ready = 1'b0;
    bus.load_busy  = 1'b0;
    bus.load_done  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.host_req) begin
          state_d        = bus.host_we ? StHostWr : StHostRd;
          // A load requested alongside the host starts right after the ack.
          pending_load_d = bus.load_start;
        end else if (bus.load_start) begin
          state_d = StLoad;
          cnt_clr = 1'b1;
        end
      end
      StHostWr: begin
        bus.mem_addr = bus.host_addr;
        bus.mem_din  = bus.host_wdata;
        if (!infer_active) begin
          bus.mem_wen    = 1'b1;
          bus.host_ack   = 1'b1;
          state_d        = pending_load_q ? StLoad : StIdle;
          cnt_clr        = pending_load_q;
          pending_load_d = 1'b0;
        end
      end
      StHostRd: begin
        bus.mem_addr = bus.host_addr;
        rd_cnt_d     = rd_cnt_q + RdCntWidth'(1);
        if (rd_cnt_q == RdCntWidth'(RD_LATENCY)) begin
          bus.host_ack   = 1'b1;
          bus.host_rdata = bus.mem_dout;
          rdata_d        = bus.mem_dout;
          rd_cnt_d       = '0;
          state_d        = pending_load_q ? StLoad : StIdle;
          cnt_clr        = pending_load_q;
          pending_load_d = 1'b0;
        end
      end
      StLoad: begin
        bus.load_busy  = 1'b1;
        bus.mem_addr   = NEURON_ADDR_WIDTH'(compose_addr(64'(neuron_idx), 64'(weight_idx),
                                                         WEIGHT_ADDR_WIDTH));
        bus.load_ready = !infer_active;
        if (bus.load_valid && !infer_active) begin
          bus.mem_din = bus.load_data;
          bus.mem_wen = 1'b1;
          cnt_inc     = 1'b1;
          if (cnt_last) state_d = StLoadDone;
        end
      end
      StLoadDone: begin
        bus.load_done = 1'b1;
        cnt_clr       = 1'b1;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, pending-load flag, read-wait counter and read-data hold register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      pending_load_q <= 1'b0;
      rd_cnt_q       <= '0;
      rdata_q        <= '0;
    end else begin
      state_q        <= state_d;
      pending_load_q <= pending_load_d;
      rd_cnt_q       <= rd_cnt_d;
      rdata_q        <= rdata_d;
    end
  end

endmodule

// File: tb/tb_if_weight_mem_arbiter.sv
// Directed bench for if_weight_mem_arbiter with a 2-cycle memory model.
module tb_if_weight_mem_arbiter;

  localparam int unsigned Ws  = 32;
  localparam int unsigned Aw  = 28;
  localparam int unsigned Ni  = 4;
  localparam int unsigned Nn  = 2;
  localparam int unsigned Waw = 10;
  localparam int unsigned Lat = 2;

  logic clk;
  logic rst;
  logic infer_active;
  int   errors;
  int   checks;
  int   done_cnt;

  logic [Ws-1:0] tb_mem [0:2047];
  logic [Ws-1:0] rd_p0, rd_p1;

  if_weight_mem_arbiter_if #(.WEIGHT_SIZE(Ws), .NEURON_ADDR_WIDTH(Aw)) ifc ();

  if_weight_mem_arbiter #(
    .WEIGHT_SIZE      (Ws),
    .NUM_INPUTS       (Ni),
    .NUM_NEURONS      (Nn),
    .NEURON_ADDR_WIDTH(Aw),
    .WEIGHT_ADDR_WIDTH(Waw),
    .RD_LATENCY       (Lat)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .infer_active(infer_active),
    .bus         (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Layer memory model: synchronous write, two-stage read pipeline.
  assign ifc.mem_dout = rd_p1;
  always @(posedge clk) begin
    if (ifc.mem_wen) tb_mem[ifc.mem_addr[10:0]] <= ifc.mem_din;
    rd_p0 <= tb_mem[ifc.mem_addr[10:0]];
    rd_p1 <= rd_p0;
  end

  initial done_cnt = 0;
  always @(posedge clk) if (ifc.load_done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    logic [Aw-1:0] ea;
    errors = 0;
    checks = 0;
    rst = 1'b0;
    infer_active = 1'b0;
    ifc.host_req = 1'b0;
    ifc.host_we = 1'b0;
    ifc.host_addr = '0;
    ifc.host_wdata = '0;
    ifc.load_start = 1'b0;
    ifc.load_valid = 1'b0;
    ifc.load_data = '0;

    // Reset state
    step();
    mid();
    chk("rst_wen", ifc.mem_wen, 0);
    chk("rst_addr", ifc.mem_addr, 0);
    chk("rst_ack", ifc.host_ack, 0);
    chk("rst_busy", ifc.load_busy, 0);
    chk("rst_ready", ifc.load_ready, 0);
    chk("rst_rdata", ifc.host_rdata, 0);
    step();
    rst = 1'b1;

    // Host write, inference idle
    ifc.host_req = 1'b1; ifc.host_we = 1'b1; ifc.host_addr = 28'h401; ifc.host_wdata = 32'hA5;
    mid();
    chk("wr_idle_wen", ifc.mem_wen, 0);
    step();
    mid();
    chk("wr_wen", ifc.mem_wen, 1);
    chk("wr_addr", ifc.mem_addr, 28'h401);
    chk("wr_din", ifc.mem_din, 32'hA5);
    chk("wr_ack", ifc.host_ack, 1);
    step();
    ifc.host_req = 1'b0; ifc.host_we = 1'b0;
    mid();
    chk("wr_after_wen", ifc.mem_wen, 0);
    chk("wr_after_addr", ifc.mem_addr, 0);
    chk("wr_mem", tb_mem[11'h401], 32'hA5);
    step();

    // Host write blocked by inference for 5 cycles
    infer_active = 1'b1;
    ifc.host_req = 1'b1; ifc.host_we = 1'b1; ifc.host_addr = 28'h002; ifc.host_wdata = 32'h1234;
    mid();
    step();
    for (int c = 0; c < 5; c++) begin
      mid();
      chk("wr_blk_wen", ifc.mem_wen, 0);
      chk("wr_blk_ack", ifc.host_ack, 0);
      step();
    end
    infer_active = 1'b0;
    mid();
    chk("wr_unblk_wen", ifc.mem_wen, 1);
    chk("wr_unblk_ack", ifc.host_ack, 1);
    chk("wr_unblk_addr", ifc.mem_addr, 28'h002);
    step();
    ifc.host_req = 1'b0; ifc.host_we = 1'b0;
    mid();
    chk("wr_unblk_mem", tb_mem[11'h002], 32'h1234);
    step();

    // Host read, latency 2, inference active (reads not blocked)
    infer_active = 1'b1;
    ifc.host_req = 1'b1; ifc.host_we = 1'b0; ifc.host_addr = 28'h002;
    mid();
    step();
    mid();
    chk("rd_c0_ack", ifc.host_ack, 0);
    chk("rd_c0_addr", ifc.mem_addr, 28'h002);
    chk("rd_c0_wen", ifc.mem_wen, 0);
    step();
    mid();
    chk("rd_c1_ack", ifc.host_ack, 0);
    step();
    mid();
    chk("rd_c2_ack", ifc.host_ack, 1);
    chk("rd_c2_rdata", ifc.host_rdata, 32'h1234);
    step();
    ifc.host_req = 1'b0; infer_active = 1'b0;
    mid();
    chk("rd_hold_rdata", ifc.host_rdata, 32'h1234);
    chk("rd_hold_ack", ifc.host_ack, 0);
    step();

    // Bulk load, gapped valid, one inference stall
    ifc.load_start = 1'b1;
    mid();
    step();
    ifc.load_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 1) begin
        ifc.load_valid = 1'b0;
        mid();
        chk("ld_gap_wen", ifc.mem_wen, 0);
        chk("ld_gap_ready", ifc.load_ready, 1);
        chk("ld_gap_busy", ifc.load_busy, 1);
        step();
      end
      if (i == 2) begin
        infer_active = 1'b1; ifc.load_valid = 1'b1; ifc.load_data = 32'hDEAD;
        mid();
        chk("ld_inf_ready", ifc.load_ready, 0);
        chk("ld_inf_wen", ifc.mem_wen, 0);
        step();
        infer_active = 1'b0;
      end
      ifc.load_valid = 1'b1; ifc.load_data = 32'hD000 + i;
      ea = 28'(((i / 4) << 10) | (i % 4));
      mid();
      chk("ld_wen", ifc.mem_wen, 1);
      chk("ld_addr", ifc.mem_addr, ea);
      chk("ld_din", ifc.mem_din, 32'hD000 + i);
      step();
    end
    ifc.load_valid = 1'b0;
    mid();
    chk("ld_done", ifc.load_done, 1);
    chk("ld_done_busy", ifc.load_busy, 0);
    step();
    mid();
    chk("ld_after_done", ifc.load_done, 0);
    chk("ld_after_busy", ifc.load_busy, 0);
    chk("ld_done_cnt", done_cnt, 1);
    chk("ld_img0", tb_mem[11'h000], 32'hD000);
    chk("ld_img4", tb_mem[11'h400], 32'hD004);
    chk("ld_img7", tb_mem[11'h403], 32'hD007);
    step();

    // Simultaneous host read and load_start: host first, load next cycle
    ifc.host_req = 1'b1; ifc.host_we = 1'b0; ifc.host_addr = 28'h401; ifc.load_start = 1'b1;
    mid();
    step();
    ifc.load_start = 1'b0;
    mid();
    chk("sim_c0_busy", ifc.load_busy, 0);
    chk("sim_c0_ack", ifc.host_ack, 0);
    step();
    mid();
    chk("sim_c1_ack", ifc.host_ack, 0);
    step();
    mid();
    chk("sim_ack", ifc.host_ack, 1);
    chk("sim_rdata", ifc.host_rdata, 32'hD005);
    step();
    // Host write arrives mid-load and must wait for load_done
    ifc.host_req = 1'b1; ifc.host_we = 1'b1; ifc.host_addr = 28'h7FF; ifc.host_wdata = 32'h77;
    for (int i = 0; i < 8; i++) begin
      ifc.load_valid = 1'b1; ifc.load_data = 32'hE0 + i;
      ea = 28'(((i / 4) << 10) | (i % 4));
      mid();
      chk("sim_ld_busy", ifc.load_busy, 1);
      chk("sim_ld_ack", ifc.host_ack, 0);
      chk("sim_ld_addr", ifc.mem_addr, ea);
      step();
    end
    ifc.load_valid = 1'b0;
    mid();
    chk("sim_done", ifc.load_done, 1);
    chk("sim_done_ack", ifc.host_ack, 0);
    step();
    mid();
    chk("sim_idle_ack", ifc.host_ack, 0);
    step();
    mid();
    chk("sim_wr_ack", ifc.host_ack, 1);
    chk("sim_wr_wen", ifc.mem_wen, 1);
    chk("sim_wr_addr", ifc.mem_addr, 28'h7FF);
    step();
    ifc.host_req = 1'b0; ifc.host_we = 1'b0;
    mid();
    chk("sim_done_cnt", done_cnt, 2);
    chk("sim_wr_mem", tb_mem[11'h7FF], 32'h77);
    step();

    // Reset after three loader words aborts without load_done
    ifc.load_start = 1'b1;
    mid();
    step();
    ifc.load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ifc.load_valid = 1'b1; ifc.load_data = 32'hF0 + i;
      mid();
      chk("rl_wen", ifc.mem_wen, 1);
      step();
    end
    #2;
    rst = 1'b0;
    #1;
    chk("rl_async_busy", ifc.load_busy, 0);
    chk("rl_async_wen", ifc.mem_wen, 0);
    chk("rl_async_ready", ifc.load_ready, 0);
    chk("rl_async_addr", ifc.mem_addr, 0);
    mid();
    step();
    rst = 1'b1;
    ifc.load_valid = 1'b0;
    mid();
    chk("rl_no_done", done_cnt, 2);
    chk("rl_idle_busy", ifc.load_busy, 0);
    step();
    ifc.load_start = 1'b1;
    mid();
    step();
    ifc.load_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ifc.load_valid = 1'b1; ifc.load_data = 32'hC0 + i;
      ea = 28'(((i / 4) << 10) | (i % 4));
      mid();
      chk("rl_re_wen", ifc.mem_wen, 1);
      chk("rl_re_addr", ifc.mem_addr, ea);
      step();
    end
    ifc.load_valid = 1'b0;
    mid();
    chk("rl_re_done", ifc.load_done, 1);
    step();
    mid();
    chk("rl_done_cnt", done_cnt, 3);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
